// File: rtl/hello_frame_decoder.sv
// HELLO banner receive decoder: maps five 7-segment codes back to characters and reports
// the rotation index (0..4) that produced the frame. Optional CHARS output under HELLO_DEC_CHARS_EN.
module hello_frame_decoder #(
  parameter int TIMEOUT = 1024
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] seg_in,
  input  logic       seg_valid,
  input  logic       seg_start,
  output logic       seg_ready,
  output logic [2:0] rot,
  output logic       rot_valid,
  output logic       rot_err
`ifdef HELLO_DEC_CHARS_EN
  ,
  output logic [14:0] chars
`endif
);

  typedef enum logic {COLLECT, CHECK} state_t;

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [2:0] BAD_CODE = 3'd7;

  state_t          state, state_next;
  logic [2:0]      idx;
  logic            bad;
  logic [CW-1:0]   idle_cnt;
  logic [2:0]      codes [5];

  logic            take;
  logic [2:0]      wr_idx;
  logic [2:0]      wr_code;
  logic            match;
  logic [2:0]      match_rot;

  function automatic logic [2:0] decode(input logic [6:0] s);
    case (s)
      7'b0001001: decode = 3'd0; // H
      7'b0000110: decode = 3'd1; // E
      7'b1000111: decode = 3'd2; // L
      7'b1000000: decode = 3'd3; // O
      default:    decode = BAD_CODE;
    endcase
  endfunction

  // Character k of the unrotated banner H,E,L,L,O.
  function automatic logic [2:0] base_char(input int k);
    case (k)
      0:       base_char = 3'd0;
      1:       base_char = 3'd1;
      2, 3:    base_char = 3'd2;
      default: base_char = 3'd3;
    endcase
  endfunction

  assign wr_idx  = seg_start ? 3'd0 : idx;
  assign wr_code = decode(seg_in);

  // Rotation r shows base_char((i+r)%5) at digit i; the five rotations are distinct.
  always_comb begin
    logic hit;
    hit       = 1'b0;
    match     = 1'b0;
    match_rot = 3'd0;
    for (int r = 0; r < 5; r++) begin
      hit = 1'b1;
      for (int i = 0; i < 5; i++)
        if (codes[i] != base_char((i + r) % 5)) hit = 1'b0;
      if (hit) begin
        match     = 1'b1;
        match_rot = 3'(r);
      end
    end
  end

  // NOTE: every output of a combinational block gets a default first, so no path infers a latch.
  always_comb begin
    state_next = state;
    seg_ready  = 1'b0;
    take       = 1'b0;
    unique case (state)
      COLLECT: begin
        seg_ready = 1'b1;
        take      = seg_valid;
        if (take && wr_idx == 3'd4) state_next = CHECK;
      end
      CHECK: state_next = COLLECT;
      default: state_next = COLLECT;
    endcase
  end

  // NOTE: state uses non-blocking assignments only; the code store is reset too because its
  // contents are observable through CHARS and must be 0 after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= COLLECT;
      idx       <= 3'd0;
      bad       <= 1'b0;
      idle_cnt  <= '0;
      rot       <= 3'd0;
      rot_valid <= 1'b0;
      rot_err   <= 1'b0;
      for (int i = 0; i < 5; i++) codes[i] <= 3'd0;
`ifdef HELLO_DEC_CHARS_EN
      chars     <= 15'd0;
`endif
    end else begin
      state     <= state_next;
      rot_valid <= 1'b0;
      rot_err   <= 1'b0;

      if (take) begin
        codes[wr_idx] <= wr_code;
        bad           <= (bad & ~seg_start) | (wr_code == BAD_CODE);
        idx           <= (wr_idx == 3'd4) ? 3'd0 : 3'(wr_idx + 3'd1);
        idle_cnt      <= '0;
      end else if (state == COLLECT && idx != 3'd0 && TIMEOUT != 0) begin
        // A stalled partial frame is silently dropped once TIMEOUT idle cycles elapse.
        if (idle_cnt == CW'(TIMEOUT - 1)) begin
          idx      <= 3'd0;
          bad      <= 1'b0;
          idle_cnt <= '0;
        end else begin
          idle_cnt <= idle_cnt + 1'b1;
        end
      end else begin
        idle_cnt <= '0;
      end

      if (state == CHECK) begin
        bad <= 1'b0;
        if (match && !bad) begin
          rot_valid <= 1'b1;
          rot       <= match_rot;
        end else begin
          rot_err   <= 1'b1;
        end
`ifdef HELLO_DEC_CHARS_EN
        chars <= {codes[0], codes[1], codes[2], codes[3], codes[4]};
`endif
      end
    end
  end

endmodule
